// File: rtl/spi_prog_loader_if.sv
// Byte-stream, write-port and status signals of the SPI program loader.
// SPI_PROG_LOADER_RDBACK_EN adds the tx readback handshake.
interface spi_prog_loader_if #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ERR_CNT_W = 8
);
    logic                 cs_n;
    logic [7:0]           rx_byte;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [ADDR_W-1:0]    wr_addr;
    logic [DATA_W-1:0]    wr_data;
    logic                 wr_sel_imem;
    logic                 wr_sel_pim;
    logic                 busy;
    logic [ERR_CNT_W-1:0] err_cnt;
`ifdef SPI_PROG_LOADER_RDBACK_EN
    logic [7:0]           tx_byte;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output cs_n, rx_byte, rx_valid, wr_ready, tx_ready,
        input  rx_ready, wr_valid, wr_addr, wr_data, wr_sel_imem, wr_sel_pim,
               busy, err_cnt, tx_byte, tx_valid
    );

    modport slave (
        input  cs_n, rx_byte, rx_valid, wr_ready, tx_ready,
        output rx_ready, wr_valid, wr_addr, wr_data, wr_sel_imem, wr_sel_pim,
               busy, err_cnt, tx_byte, tx_valid
    );
`else
    modport master (
        output cs_n, rx_byte, rx_valid, wr_ready,
        input  rx_ready, wr_valid, wr_addr, wr_data, wr_sel_imem, wr_sel_pim,
               busy, err_cnt
    );

    modport slave (
        input  cs_n, rx_byte, rx_valid, wr_ready,
        output rx_ready, wr_valid, wr_addr, wr_data, wr_sel_imem, wr_sel_pim,
               busy, err_cnt
    );
`endif
endinterface

// File: rtl/spi_prog_loader.sv
// Parses programmer opcodes from the SPI byte stream into word writes to IMEM or PIM.
// Define SPI_PROG_LOADER_RDBACK_EN to enable opcode 0x03 (read back last written word).
module spi_prog_loader #(
    parameter int         ADDR_W      = 32,
    parameter int         DATA_W      = 32,
    parameter logic [3:0] IMEM_REGION = 4'h1,
    parameter logic [3:0] PIM_REGION  = 4'h2,
    parameter int         ERR_CNT_W   = 8
) (
    input  logic           clk,
    input  logic           reset,
    spi_prog_loader_if.slave bus
);

    localparam logic [7:0]           OP_ADDR   = 8'h01;
    localparam logic [7:0]           OP_DATA   = 8'h02;
    localparam logic [ADDR_W-1:0]    WORD_STEP = ADDR_W'(4);
    localparam logic [ERR_CNT_W-1:0] ERR_ONE   = ERR_CNT_W'(1);
`ifdef SPI_PROG_LOADER_RDBACK_EN
    localparam logic [7:0]           OP_RDBACK = 8'h03;
`endif

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        WRITE
`ifdef SPI_PROG_LOADER_RDBACK_EN
        , RDBACK
`endif
    } state_t;

    state_t               state;
    logic [ADDR_W-1:0]    addr_reg;
    logic [ADDR_W-1:0]    addr_shadow;
    logic [DATA_W-1:0]    data_reg;
    logic [1:0]           byte_cnt;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic                 rx_ready;
    logic                 wr_valid;
    logic                 sel_imem;
    logic                 sel_pim;
    logic                 busy;
`ifdef SPI_PROG_LOADER_RDBACK_EN
    logic [DATA_W-1:0]    last_data;
    logic [DATA_W-1:0]    tx_shift;
    logic                 tx_valid;
`endif

    logic       xfer;
    logic [3:0] region;
    logic       region_ok;
    logic       aligned;

    // Bytes presented while chip select is high are dropped, not consumed.
    assign xfer      = bus.rx_valid & rx_ready & ~bus.cs_n;
    assign region    = addr_reg[ADDR_W-1 -: 4];
    assign region_ok = (region == IMEM_REGION) || (region == PIM_REGION);
    assign aligned   = (addr_reg[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            addr_reg    <= '0;
            addr_shadow <= '0;
            data_reg    <= '0;
            byte_cnt    <= '0;
            err_cnt     <= '0;
            rx_ready    <= 1'b1;
            wr_valid    <= 1'b0;
            sel_imem    <= 1'b0;
            sel_pim     <= 1'b0;
            busy        <= 1'b0;
`ifdef SPI_PROG_LOADER_RDBACK_EN
            last_data   <= '0;
            tx_shift    <= '0;
            tx_valid    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        if (bus.rx_byte == OP_ADDR) begin
                            state       <= ADDR;
                            byte_cnt    <= '0;
                            addr_shadow <= addr_reg;
                            busy        <= 1'b1;
                        end else if (bus.rx_byte == OP_DATA) begin
                            state    <= DATA;
                            byte_cnt <= '0;
                            busy     <= 1'b1;
                        end
`ifdef SPI_PROG_LOADER_RDBACK_EN
                        else if (bus.rx_byte == OP_RDBACK) begin
                            state    <= RDBACK;
                            byte_cnt <= '0;
                            tx_shift <= last_data;
                            tx_valid <= 1'b1;
                            rx_ready <= 1'b0;
                            busy     <= 1'b1;
                        end
`endif
                        else if (err_cnt != '1) begin
                            err_cnt <= err_cnt + ERR_ONE;
                        end
                    end
                end

                // An aborted address frame restores the address held before the frame began.
                ADDR: begin
                    if (bus.cs_n) begin
                        state    <= IDLE;
                        addr_reg <= addr_shadow;
                        busy     <= 1'b0;
                    end else if (xfer) begin
                        addr_reg <= {addr_reg[ADDR_W-9:0], bus.rx_byte};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                DATA: begin
                    if (bus.cs_n) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (xfer) begin
                        data_reg <= {data_reg[DATA_W-9:0], bus.rx_byte};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            if (region_ok && aligned) begin
                                state    <= WRITE;
                                wr_valid <= 1'b1;
                                sel_imem <= (region == IMEM_REGION);
                                sel_pim  <= (region == PIM_REGION);
                                rx_ready <= 1'b0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                if (err_cnt != '1) begin
                                    err_cnt <= err_cnt + ERR_ONE;
                                end
                            end
                        end
                    end
                end

                // Post-increment lets consecutive data frames fill consecutive words.
                WRITE: begin
                    if (bus.wr_ready) begin
                        addr_reg <= addr_reg + WORD_STEP;
                        state    <= IDLE;
                        wr_valid <= 1'b0;
                        sel_imem <= 1'b0;
                        sel_pim  <= 1'b0;
                        rx_ready <= 1'b1;
                        busy     <= 1'b0;
`ifdef SPI_PROG_LOADER_RDBACK_EN
                        last_data <= data_reg;
`endif
                    end
                end

`ifdef SPI_PROG_LOADER_RDBACK_EN
                RDBACK: begin
                    if (bus.tx_ready) begin
                        tx_shift <= {tx_shift[DATA_W-9:0], 8'h00};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state    <= IDLE;
                            tx_valid <= 1'b0;
                            rx_ready <= 1'b1;
                            busy     <= 1'b0;
                        end
                    end
                end
`endif

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.rx_ready    = rx_ready;
    assign bus.wr_valid    = wr_valid;
    assign bus.wr_addr     = {addr_reg[ADDR_W-1:2], 2'b00};
    assign bus.wr_data     = data_reg;
    assign bus.wr_sel_imem = sel_imem;
    assign bus.wr_sel_pim  = sel_pim;
    assign bus.busy        = busy;
    assign bus.err_cnt     = err_cnt;
`ifdef SPI_PROG_LOADER_RDBACK_EN
    assign bus.tx_byte     = tx_shift[DATA_W-1 -: 8];
    assign bus.tx_valid    = tx_valid;
`endif

endmodule

// File: tb/tb_spi_prog_loader.sv
// Randomized bench for spi_prog_loader with a frame-level model of address, errors and writes.
// SPI_PROG_LOADER_RDBACK_EN also exercises the readback opcode.
module tb_spi_prog_loader;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    spi_prog_loader_if bus ();

    spi_prog_loader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Model state: current word address, expected error count, queue of {sel_imem, addr, data}.
    logic [31:0] model_addr;
    int          model_err;
    logic [64:0] exp_q[$];
    logic [64:0] mon_entry;
    int          stall_target = 0;
    int          wait_cnt     = 0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Write-port responder: stalls each write for stall_target cycles, then scores it.
    always @(negedge clk) begin
        if (reset) begin
            bus.wr_ready = 1'b0;
            wait_cnt     = 0;
        end else if (bus.wr_valid) begin
            checkOutput("stall_rx_ready", bus.rx_ready, 0);
            checkOutput("sel_onehot", bus.wr_sel_imem ^ bus.wr_sel_pim, 1);
            if (exp_q.size() != 0) begin
                checkOutput("stable_addr", bus.wr_addr, exp_q[0][63:32]);
            end
            if (wait_cnt >= stall_target) begin
                bus.wr_ready = 1'b1;
                wait_cnt     = 0;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_write", bus.wr_valid, 0);
                end else begin
                    mon_entry = exp_q.pop_front();
                    checkOutput("wr_addr", bus.wr_addr, mon_entry[63:32]);
                    checkOutput("wr_data", bus.wr_data, mon_entry[31:0]);
                    checkOutput("wr_sel_imem", bus.wr_sel_imem, mon_entry[64]);
                end
            end else begin
                bus.wr_ready = 1'b0;
                wait_cnt++;
            end
        end else begin
            checkOutput("idle_sels", {bus.wr_sel_imem, bus.wr_sel_pim}, 0);
            bus.wr_ready = 1'($urandom_range(0, 1));
            wait_cnt     = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Presents one byte from a negedge and holds it until the loader accepts it.
    task automatic applyStimulus(input logic [7:0] b);
        int   cnt = 0;
        logic rdy = 1'b0;
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        while (!rdy) begin
            rdy = bus.rx_ready;
            @(negedge clk);
            if (!rdy) begin
                cnt++;
                if (cnt > 200) begin
                    checkOutput("rx_timeout", bus.rx_ready, 1);
                    break;
                end
            end
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic bumpErr();
        if (model_err < 255) model_err++;
    endtask

    task automatic sendAddrFrame(input logic [31:0] a);
        applyStimulus(8'h01);
        for (int i = 3; i >= 0; i--) applyStimulus(a[8*i +: 8]);
        model_addr = a;
    endtask

    task automatic sendDataFrame(input logic [31:0] d);
        logic [3:0] region;
        logic       ok;
        region = model_addr[31:28];
        ok     = (region == 4'h1 || region == 4'h2) && (model_addr[1:0] == 2'b00);
        if (ok) begin
            exp_q.push_back({region == 4'h1, {model_addr[31:2], 2'b00}, d});
            model_addr = model_addr + 32'd4;
        end else begin
            bumpErr();
        end
        applyStimulus(8'h02);
        for (int i = 3; i >= 0; i--) applyStimulus(d[8*i +: 8]);
        checkOutput("wr_latency", bus.wr_valid, ok);
    endtask

    task automatic sendBadOp(input logic [7:0] b);
        applyStimulus(b);
        bumpErr();
    endtask

    // Starts a frame, sends fewer than four payload bytes, then pulses cs_n with a stray byte.
    task automatic abortFrame(input logic [7:0] op, input int nbytes);
        applyStimulus(op);
        for (int i = 0; i < nbytes; i++) applyStimulus(8'($urandom));
        bus.cs_n     = 1'b1;
        bus.rx_byte  = 8'($urandom);
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.cs_n     = 1'b0;
        bus.rx_valid = 1'b0;
        checkOutput("abort_busy", bus.busy, 0);
    endtask

    task automatic waitIdle();
        int cnt = 0;
        while ((bus.busy || exp_q.size() != 0) && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 200) checkOutput("idle_timeout", bus.busy, 0);
    endtask

    task automatic checkIdleErr(input string tag);
        waitIdle();
        checkOutput(tag, bus.err_cnt, model_err);
    endtask

`ifdef SPI_PROG_LOADER_RDBACK_EN
    task automatic readBack(input logic [31:0] word);
        int idx    = 0;
        int cycles = 0;
        applyStimulus(8'h03);
        while (idx < 4 && cycles < 200) begin
            if (bus.tx_valid) begin
                checkOutput("tx_byte", bus.tx_byte, 8'(word >> (24 - 8 * idx)));
                checkOutput("rb_rx_ready", bus.rx_ready, 0);
                bus.tx_ready = 1'($urandom_range(0, 1));
                if (bus.tx_ready) idx++;
            end else begin
                bus.tx_ready = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        bus.tx_ready = 1'b0;
        if (idx < 4) checkOutput("rb_timeout", idx, 4);
        checkOutput("rb_tx_valid_done", bus.tx_valid, 0);
        checkOutput("rb_rx_ready_done", bus.rx_ready, 1);
    endtask
`endif

    initial begin
        reset        = 1'b1;
        bus.cs_n     = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'h00;
`ifdef SPI_PROG_LOADER_RDBACK_EN
        bus.tx_ready = 1'b0;
`endif
        model_addr = 32'h0;
        model_err  = 0;
        repeat (3) @(negedge clk);

        checkOutput("rst_rx_ready", bus.rx_ready, 1);
        checkOutput("rst_wr_valid", bus.wr_valid, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_err_cnt", bus.err_cnt, 0);
        checkOutput("rst_wr_addr", bus.wr_addr, 0);
        checkOutput("rst_wr_data", bus.wr_data, 0);

        reset    = 1'b0;
        bus.cs_n = 1'b0;
        @(negedge clk);

        // Basic IMEM write, auto-increment, and increment across the IMEM/PIM boundary.
        stall_target = 0;
        sendAddrFrame(32'h1000_0000);
        sendDataFrame(32'hDEAD_BEEF);
        sendDataFrame(32'h0123_4567);
        sendAddrFrame(32'h1FFF_FFFC);
        sendDataFrame(32'hA5A5_0001);
        sendDataFrame(32'hA5A5_0002);
        checkIdleErr("err_after_imem");

        // PIM writes with a five-cycle stall each.
        stall_target = 5;
        sendAddrFrame(32'h2000_0000);
        sendDataFrame(32'h1);
        sendDataFrame(32'h2);
        sendDataFrame(32'h3);
        checkIdleErr("err_after_pim");

        // Unmapped region and misaligned address both drop the frame.
        stall_target = 0;
        sendAddrFrame(32'h3000_0000);
        sendDataFrame(32'h5555_AAAA);
        checkIdleErr("err_bad_region");
        sendAddrFrame(32'h1000_0002);
        sendDataFrame(32'h6666_7777);
        checkIdleErr("err_misaligned");

        // Aborted address frame keeps the previously loaded address.
        sendAddrFrame(32'h1000_0100);
        abortFrame(8'h01, 2);
        sendDataFrame(32'h1122_3344);
        abortFrame(8'h02, 3);
        checkIdleErr("err_after_abort");

`ifndef SPI_PROG_LOADER_RDBACK_EN
        sendBadOp(8'h03);
        checkIdleErr("err_op03_unknown");
`endif

        for (int it = 0; it < 60; it++) begin
            int          choice;
            logic [31:0] a;
            logic [7:0]  b;
            stall_target = $urandom_range(0, 3);
            choice       = $urandom_range(0, 5);
            case (choice)
                0: begin
                    case ($urandom_range(0, 3))
                        0:       a[31:28] = 4'h1;
                        1:       a[31:28] = 4'h2;
                        2:       a[31:28] = 4'h3;
                        default: a[31:28] = 4'($urandom);
                    endcase
                    a[27:0] = 28'($urandom);
                    if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
                    sendAddrFrame(a);
                end
                1, 2: sendDataFrame($urandom);
                3: begin
                    b = 8'($urandom);
`ifdef SPI_PROG_LOADER_RDBACK_EN
                    if (b >= 8'h01 && b <= 8'h03) b = 8'hFF;
`else
                    if (b == 8'h01 || b == 8'h02) b = 8'hFF;
`endif
                    sendBadOp(b);
                end
                default: abortFrame(($urandom_range(0, 1) != 0) ? 8'h01 : 8'h02, $urandom_range(0, 3));
            endcase
            if (it % 10 == 9) checkIdleErr("err_random");
        end
        checkIdleErr("err_random_end");

        // Error counter saturation.
        stall_target = 0;
        repeat (300) sendBadOp(8'h7F);
        checkIdleErr("err_saturated");
        checkOutput("err_sat_value", bus.err_cnt, 8'hFF);

        // Reset while the second data byte is presented.
        applyStimulus(8'h02);
        applyStimulus(8'h9C);
        bus.rx_byte  = 8'h3E;
        bus.rx_valid = 1'b1;
        reset        = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        checkOutput("rst_mid_busy", bus.busy, 0);
        checkOutput("rst_mid_err", bus.err_cnt, 0);
        checkOutput("rst_mid_rx_ready", bus.rx_ready, 1);
        reset      = 1'b0;
        model_addr = 32'h0;
        model_err  = 0;
        @(negedge clk);

        // Reset while a write is stalled: the write is dropped and the address clears.
        stall_target = 1000;
        sendAddrFrame(32'h1000_0040);
        sendDataFrame(32'hBAD0_0001);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checkOutput("rst_write_wr_valid", bus.wr_valid, 0);
        reset        = 1'b0;
        model_addr   = 32'h0;
        model_err    = 0;
        stall_target = 0;
        @(negedge clk);
        sendDataFrame(32'h0000_BEEF);
        checkIdleErr("err_after_write_reset");

`ifdef SPI_PROG_LOADER_RDBACK_EN
        readBack(32'h0);
        sendAddrFrame(32'h1000_0000);
        sendDataFrame(32'hCAFE_F00D);
        waitIdle();
        readBack(32'hCAFE_F00D);
        checkIdleErr("err_after_readback");
`endif

        waitIdle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/spi_prog_loader.md
Name: spi_prog_loader

Overview:
- Command parser downstream of the SPI slave byte receiver inside mpw_top.
- Consumes the byte stream that the external programmer sends while SPIRSTN is released.
- Assembles 32-bit address and data words, then issues single-word writes to either the instruction memory (0x1xxx_xxxx) or a PIM buffer (0x2xxx_xxxx) over a valid/ready port.
- Holds the RISC-V core off the memories only via the top-level reset; it has no other interaction with the core.

Parameters:
- ADDR_W, 32, width of the address word assembled from the stream.
- DATA_W, 32, width of the data word; must be 32 (4 bytes per frame).
- IMEM_REGION, 4'h1, value of addr[31:28] that selects instruction memory.
- PIM_REGION, 4'h2, value of addr[31:28] that selects the PIM buffer.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cs_n  in  1  SPI chip select, already synchronised to clk; high means frame idle.
- rx_byte  in  8  received byte from the SPI slave.
- rx_valid  in  1  rx_byte valid for one transfer.
- rx_ready  out  1  loader can accept a byte.
- wr_valid  out  1  write request pending.
- wr_ready  in  1  target accepts the write.
- wr_addr  out  32  word address; bits [1:0] always 0.
- wr_data  out  32  write data.
- wr_sel_imem  out  1  write targets instruction memory.
- wr_sel_pim  out  1  write targets the PIM buffer.
- busy  out  1  high in any state other than IDLE.
- err_cnt  out  ERR_CNT_W  count of dropped frames, saturating.

Behaviour:
- Reset: state=IDLE; addr_reg=0, data_reg=0, byte_cnt=0, err_cnt=0.
  - All outputs are 0 except rx_ready=1.
- A byte transfer occurs when rx_valid and rx_ready are both high on the same clock edge.
- rx_ready is 1 in IDLE, ADDR and DATA, and 0 in WRITE. The SPI slave must hold the byte until it is accepted.
- IDLE:
  - Opcode 0x01 -> ADDR, byte_cnt=0.
  - Opcode 0x02 -> DATA, byte_cnt=0.
  - Any other opcode -> stay in IDLE, err_cnt+1.
- ADDR:
  - Each byte shifts in MSB first: addr_reg <= {addr_reg[23:0], byte}.
  - After the 4th byte -> IDLE.
  - addr_reg is not cleared between frames; the last loaded address persists.
- DATA:
  - Each byte shifts into data_reg MSB first.
  - On the 4th byte, decode addr_reg[31:28]:
    - matches IMEM_REGION or PIM_REGION -> WRITE;
    - no match -> IDLE, err_cnt+1, no write issued.
  - If addr_reg[1:0] != 0 -> IDLE, err_cnt+1, no write issued.
- WRITE:
  - wr_valid=1; wr_addr, wr_data and the selects are stable until accepted.
  - On wr_valid & wr_ready: addr_reg <= addr_reg + 4 (wraps mod 2^32), then -> IDLE.
  - Auto-increment means back-to-back 0x02 frames fill consecutive words without resending the address.
- Exactly one of wr_sel_imem or wr_sel_pim is high while wr_valid is high; both are 0 otherwise.
- Latency: wr_valid rises on the cycle after the 4th data byte is accepted.
- Abort: cs_n high in ADDR or DATA -> IDLE next cycle.
  - A partial address is discarded (addr_reg restored to its pre-frame value; keep a shadow register).
  - A partial data word is discarded.
  - err_cnt is unchanged.
- cs_n high in WRITE has no effect; the write completes.
- A byte with rx_valid on the same cycle that cs_n is high is ignored.
- err_cnt saturates at all-ones.
- busy is the inverse of (state==IDLE).
- Reset asserted mid-frame or mid-write returns everything to reset values on the next edge.
  - Any pending wr_valid drops with no completion.

Optional Feature:
- Macro: SPI_PROG_LOADER_RDBACK_EN.
- When defined, adds:
  - output tx_byte[7:0];
  - output tx_valid;
  - input tx_ready;
  - opcode 0x03 (accepted in IDLE).
- Opcode 0x03 returns the last written data word on tx_byte, MSB first, as 4 bytes, using a valid/ready handshake. rx_ready is 0 until all 4 bytes are sent.
- The returned word is 0 after reset.
- When not defined:
  - the tx ports do not exist;
  - 0x03 is an unknown opcode (err_cnt+1).

Test Plan:
- Bytes 01 10 00 00 00, then 02 DE AD BE EF, wr_ready=1 -> one write: wr_addr=0x1000_0000, wr_data=0xDEADBEEF, wr_sel_imem=1; addr_reg then reads 0x1000_0004.
- Address 0x2000_0000, then three 02 frames with data 1, 2, 3 and wr_ready held low for 5 cycles on each -> writes to 0x2000_0000, 0x2000_0004, 0x2000_0008 with wr_sel_pim=1; rx_ready=0 throughout each stall; no byte lost.
- Address 0x3000_0000, then 02 + 4 bytes -> no wr_valid, err_cnt=1. Then address 0x1000_0002 + data frame -> no write, err_cnt=2.
- Address frame 0x1000_0100 loaded, then 01 AA BB followed by cs_n pulse high, then 02 11 22 33 44 -> write to 0x1000_0100 with data 0x11223344.
- 300 bytes of opcode 0x7F -> err_cnt=0xFF (saturated). Reset asserted during DATA byte 2 -> busy=0 and err_cnt=0 the next cycle.
- (SPI_PROG_LOADER_RDBACK_EN) write 0xCAFEF00D, then opcode 03 -> tx_byte sequence CA FE F0 0D; with tx_ready toggling, each byte is held until accepted.
